// File: rtl/control_sequencer.sv
// Hardwired T-state control unit for the single-bus CPU datapath.
// Fetch T0-T2, execute T3-T5; all strobes are Moore decodes.
module control_sequencer #(
  parameter int OPW  = 5,
  parameter int ALUW = 4
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [31:0]     ir,
  input  logic            mem_rdy,
  input  logic            stop,
  output logic            PCout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            Rout,
  output logic            MARin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            Rin,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            IncPC,
  output logic            Read,
  output logic [ALUW-1:0] alu_op,
  output logic            run,
  output logic            illegal_op
);

  typedef enum logic [2:0] {
    RST_S, T0, T1, T2, T3, T4, T5, HALT_S
  } state_e;

  state_e          state_q, state_d;
  logic [OPW-1:0]  op_q, op_d;
  logic            pend_q, pend_d;
  logic            wait_q, wait_d;
  logic            tern, unary, is_nop, is_halt, done;
  logic [ALUW-1:0] fn;
  logic            unused_ir;

  assign unused_ir = ^ir[31-OPW:0];

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= RST_S;
      op_q    <= '0;
      pend_q  <= 1'b0;
      wait_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      pend_q  <= pend_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    tern    = 1'b0;
    unary   = 1'b0;
    is_nop  = 1'b0;
    is_halt = 1'b0;
    fn      = '0;
    case (op_q)
      OPW'(5'b00011): begin tern = 1'b1; fn = ALUW'(0); end
      OPW'(5'b00100): begin tern = 1'b1; fn = ALUW'(1); end
      OPW'(5'b00101): begin tern = 1'b1; fn = ALUW'(2); end
      OPW'(5'b00110): begin tern = 1'b1; fn = ALUW'(3); end
      OPW'(5'b00111): begin tern = 1'b1; fn = ALUW'(4); end
      OPW'(5'b01000): begin tern = 1'b1; fn = ALUW'(5); end
      OPW'(5'b01001): begin tern = 1'b1; fn = ALUW'(6); end
      OPW'(5'b01010): begin tern = 1'b1; fn = ALUW'(7); end
      OPW'(5'b10000): begin unary = 1'b1; fn = ALUW'(8); end
      OPW'(5'b10001): begin unary = 1'b1; fn = ALUW'(9); end
      OPW'(5'b11010): is_nop = 1'b1;
      OPW'(5'b11011): is_halt = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    pend_d     = pend_q | stop;
    wait_d     = 1'b0;
    done       = 1'b0;
    PCout      = 1'b0;
    Zlowout    = 1'b0;
    MDRout     = 1'b0;
    Rout       = 1'b0;
    MARin      = 1'b0;
    PCin       = 1'b0;
    MDRin      = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    Rin        = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    alu_op     = '0;
    illegal_op = 1'b0;
    run        = (state_q != RST_S) && (state_q != HALT_S);
    unique case (state_q)
      RST_S: state_d = T0;
      T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin     = 1'b1;
        state_d = T1;
      end
      T1: begin
        // wait_q marks a stalled T1 so PC only loads once per fetch
        Zlowout = 1'b1;
        PCin    = ~wait_q;
        Read    = 1'b1;
        MDRin   = 1'b1;
        if (mem_rdy) state_d = T2;
        else         wait_d  = 1'b1;
      end
      T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        op_d    = ir[31 -: OPW];
        state_d = T3;
      end
      T3: begin
        if (tern) begin
          Grb     = 1'b1;
          Rout    = 1'b1;
          Yin     = 1'b1;
          state_d = T4;
        end else if (unary) begin
          Grb     = 1'b1;
          Rout    = 1'b1;
          Zin     = 1'b1;
          alu_op  = fn;
          state_d = T4;
        end else if (is_halt) begin
          state_d = HALT_S;
        end else begin
          illegal_op = ~is_nop;
          done       = 1'b1;
        end
      end
      T4: begin
        if (tern) begin
          Grc     = 1'b1;
          Rout    = 1'b1;
          Zin     = 1'b1;
          alu_op  = fn;
          state_d = T5;
        end else begin
          Zlowout = 1'b1;
          Gra     = 1'b1;
          Rin     = 1'b1;
          done    = 1'b1;
        end
      end
      T5: begin
        Zlowout = 1'b1;
        Gra     = 1'b1;
        Rin     = 1'b1;
        done    = 1'b1;
      end
      HALT_S: state_d = HALT_S;
    endcase
    if (done) state_d = pend_d ? HALT_S : T0;
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer against a per-instruction
// expected-strobe model built from the opcode classes.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] ir = '0;
  logic        mem_rdy = 1'b0;
  logic        stop = 1'b0;
  logic PCout, Zlowout, MDRout, Rout, MARin, PCin, MDRin, IRin;
  logic Yin, Zin, Rin, Gra, Grb, Grc, IncPC, Read, run, illegal_op;
  logic [3:0]  alu_op;

  int checks = 0;
  int failures = 0;

  localparam logic [21:0] M_PCOUT = 22'(1) << 21;
  localparam logic [21:0] M_ZLO   = 22'(1) << 20;
  localparam logic [21:0] M_MDRO  = 22'(1) << 19;
  localparam logic [21:0] M_ROUT  = 22'(1) << 18;
  localparam logic [21:0] M_MARIN = 22'(1) << 17;
  localparam logic [21:0] M_PCIN  = 22'(1) << 16;
  localparam logic [21:0] M_MDRIN = 22'(1) << 15;
  localparam logic [21:0] M_IRIN  = 22'(1) << 14;
  localparam logic [21:0] M_YIN   = 22'(1) << 13;
  localparam logic [21:0] M_ZIN   = 22'(1) << 12;
  localparam logic [21:0] M_RIN   = 22'(1) << 11;
  localparam logic [21:0] M_GRA   = 22'(1) << 10;
  localparam logic [21:0] M_GRB   = 22'(1) << 9;
  localparam logic [21:0] M_GRC   = 22'(1) << 8;
  localparam logic [21:0] M_INC   = 22'(1) << 7;
  localparam logic [21:0] M_READ  = 22'(1) << 6;
  localparam logic [21:0] M_RUN   = 22'(1) << 5;
  localparam logic [21:0] M_ILL   = 22'(1) << 4;

  control_sequencer dut (
    .clock(clock), .clear(clear), .ir(ir),
    .mem_rdy(mem_rdy), .stop(stop),
    .PCout(PCout), .Zlowout(Zlowout),
    .MDRout(MDRout), .Rout(Rout),
    .MARin(MARin), .PCin(PCin),
    .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .Rin(Rin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .IncPC(IncPC), .Read(Read),
    .alu_op(alu_op), .run(run),
    .illegal_op(illegal_op)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic logic [21:0] obs();
    return {PCout, Zlowout, MDRout, Rout, MARin, PCin,
            MDRin, IRin, Yin, Zin, Rin, Gra, Grb, Grc,
            IncPC, Read, run, illegal_op, alu_op};
  endfunction

  // Expected per-cycle strobes for one instruction starting at T0
  logic [21:0] exp_q[$];
  bit          mr_q[$];
  bit          st_q[$];
  int          t2_idx;
  bit          halt_after;
  bit          pend_m;

  task automatic push(input logic [21:0] e, input bit mr);
    exp_q.push_back(e);
    mr_q.push_back(mr);
  endtask

  task automatic plan(input logic [4:0] op, input int waits,
                      input int stop_at);
    int o;
    exp_q.delete();
    mr_q.delete();
    st_q.delete();
    halt_after = 1'b0;
    o = int'(op);
    push(M_PCOUT | M_MARIN | M_INC | M_ZIN | M_RUN,
         bit'($urandom_range(0, 1)));
    for (int w = 0; w <= waits; w++)
      push(M_ZLO | M_READ | M_MDRIN | M_RUN | ((w == 0) ? M_PCIN : '0),
           w == waits);
    push(M_MDRO | M_IRIN | M_RUN, bit'($urandom_range(0, 1)));
    t2_idx = exp_q.size() - 1;
    if (o >= 3 && o <= 10) begin
      push(M_GRB | M_ROUT | M_YIN | M_RUN, 1'b0);
      push(M_GRC | M_ROUT | M_ZIN | M_RUN | 22'(o - 3), 1'b1);
      push(M_ZLO | M_GRA | M_RIN | M_RUN, 1'b0);
    end else if (o == 16 || o == 17) begin
      push(M_GRB | M_ROUT | M_ZIN | M_RUN | 22'(o - 8), 1'b1);
      push(M_ZLO | M_GRA | M_RIN | M_RUN, 1'b0);
    end else if (o == 26) begin
      push(M_RUN, 1'b1);
    end else if (o == 27) begin
      push(M_RUN, 1'b0);
      halt_after = 1'b1;
    end else begin
      push(M_RUN | M_ILL, 1'b1);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      st_q.push_back(i == stop_at);
      if (i == stop_at) pend_m = 1'b1;
    end
    if (pend_m) halt_after = 1'b1;
  endtask

  task automatic do_reset();
    clear = 1'b1;
    stop = 1'b0;
    mem_rdy = 1'b0;
    pend_m = 1'b0;
    @(posedge clock); #1;
    clear = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs() !== '0) begin
        failures++;
        $display("FAIL reset_hold got=%h exp=0", obs());
      end
      @(posedge clock); #1;
    end
    clear = 1'b0;
    checks++;
    if (obs() !== '0) begin
      failures++;
      $display("FAIL reset_rst_s got=%h exp=0", obs());
    end
    @(posedge clock); #1;
    checks++;
    if (obs() !== (M_PCOUT | M_MARIN | M_INC | M_ZIN | M_RUN)) begin
      failures++;
      $display("FAIL reset_t0 got=%h", obs());
    end
    pend_m = 1'b0;
  endtask

  task automatic test_shr();
    ir = 32'h39918000;
    plan(5'b00111, 0, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      mem_rdy = mr_q[i]; stop = st_q[i];
      checks++;
      if (obs() !== exp_q[i]) begin
        failures++;
        $display("FAIL shr c%0d got=%h exp=%h", i, obs(), exp_q[i]);
      end
      @(posedge clock); #1;
      if (i == t2_idx) ir = $urandom;
    end
    checks++;
    if (obs() !== exp_q[0]) begin
      failures++;
      $display("FAIL shr_next_t0 got=%h exp=%h", obs(), exp_q[0]);
    end
  endtask

  task automatic test_not();
    ir = 32'h8A280000;
    plan(5'b10001, 0, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      mem_rdy = mr_q[i]; stop = st_q[i];
      checks++;
      if (obs() !== exp_q[i]) begin
        failures++;
        $display("FAIL not c%0d got=%h exp=%h", i, obs(), exp_q[i]);
      end
      @(posedge clock); #1;
      if (i == t2_idx) ir = $urandom;
    end
  endtask

  task automatic test_wait();
    ir = {5'b00011, 27'h0123456};
    plan(5'b00011, 3, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      mem_rdy = mr_q[i]; stop = st_q[i];
      checks++;
      if (obs() !== exp_q[i]) begin
        failures++;
        $display("FAIL wait c%0d got=%h exp=%h", i, obs(), exp_q[i]);
      end
      @(posedge clock); #1;
      if (i == t2_idx) ir = $urandom;
    end
  endtask

  task automatic test_illegal();
    ir = {5'b11111, 27'h0};
    plan(5'b11111, 1, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      mem_rdy = mr_q[i]; stop = st_q[i];
      checks++;
      if (obs() !== exp_q[i]) begin
        failures++;
        $display("FAIL illegal c%0d got=%h exp=%h", i, obs(), exp_q[i]);
      end
      @(posedge clock); #1;
      if (i == t2_idx) ir = $urandom;
    end
  endtask

  task automatic test_clear_mid();
    ir = {5'b00011, 27'h0};
    plan(5'b00011, 0, -1);
    for (int i = 0; i <= 4; i++) begin
      mem_rdy = mr_q[i]; stop = st_q[i];
      checks++;
      if (obs() !== exp_q[i]) begin
        failures++;
        $display("FAIL clrmid c%0d got=%h exp=%h", i, obs(), exp_q[i]);
      end
      if (i < 4) begin
        @(posedge clock); #1;
      end
    end
    clear = 1'b1;
    #1;
    checks++;
    if (obs() !== '0) begin
      failures++;
      $display("FAIL clrmid_async got=%h exp=0", obs());
    end
    @(posedge clock); #1;
    clear = 1'b0;
    pend_m = 1'b0;
    checks++;
    if (obs() !== '0) begin
      failures++;
      $display("FAIL clrmid_rst_s got=%h exp=0", obs());
    end
    @(posedge clock); #1;
    checks++;
    if (obs() !== exp_q[0]) begin
      failures++;
      $display("FAIL clrmid_t0 got=%h exp=%h", obs(), exp_q[0]);
    end
  endtask

  task automatic test_stop();
    ir = {5'b00011, 27'h0};
    plan(5'b00011, 0, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      mem_rdy = mr_q[i]; stop = st_q[i];
      checks++;
      if (obs() !== exp_q[i]) begin
        failures++;
        $display("FAIL stop c%0d got=%h exp=%h", i, obs(), exp_q[i]);
      end
      @(posedge clock); #1;
    end
    for (int k = 0; k < 10; k++) begin
      mem_rdy = 1'b1;
      stop = 1'b0;
      checks++;
      if (obs() !== '0) begin
        failures++;
        $display("FAIL stop_halt k%0d got=%h exp=0", k, obs());
      end
      @(posedge clock); #1;
    end
    do_reset();
  endtask

  task automatic test_halt();
    ir = {5'b11011, 27'h0};
    plan(5'b11011, 0, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      mem_rdy = mr_q[i]; stop = st_q[i];
      checks++;
      if (obs() !== exp_q[i]) begin
        failures++;
        $display("FAIL halt c%0d got=%h exp=%h", i, obs(), exp_q[i]);
      end
      @(posedge clock); #1;
    end
    for (int k = 0; k < 10; k++) begin
      mem_rdy = bit'($urandom_range(0, 1));
      checks++;
      if (obs() !== '0) begin
        failures++;
        $display("FAIL halt_hold k%0d got=%h exp=0", k, obs());
      end
      @(posedge clock); #1;
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic [4:0] op;
    int sa;
    for (int n = 0; n < 40; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'b11011 && $urandom_range(0, 3) != 0) op = 5'b11010;
      sa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 6)) : -1;
      ir = {op, 27'($urandom)};
      plan(op, int'($urandom_range(0, 3)), sa);
      for (int i = 0; i < exp_q.size(); i++) begin
        mem_rdy = mr_q[i]; stop = st_q[i];
        checks++;
        if (obs() !== exp_q[i]) begin
          failures++;
          $display("FAIL rand n%0d op%0d c%0d got=%h exp=%h",
                   n, op, i, obs(), exp_q[i]);
        end
        @(posedge clock); #1;
        if (i == t2_idx) ir = $urandom;
      end
      if (halt_after) begin
        stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (obs() !== '0) begin
            failures++;
            $display("FAIL rand_halt n%0d got=%h exp=0", n, obs());
          end
          @(posedge clock); #1;
        end
        do_reset();
      end
    end
  endtask

  initial begin
    pend_m = 1'b0;
    test_reset();
    test_shr();
    test_not();
    test_wait();
    test_illegal();
    test_clear_mid();
    test_stop();
    test_halt();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
